// File: rtl/fetch_buffer.sv
// Instruction fetch buffer: one outstanding icache request, next-PC
// prediction per returned instruction and a DEPTH-entry decode queue.
module fetch_buffer #(
    parameter int                ADDR_W   = 17,
    parameter int                DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic [ADDR_W-1:0]          flush_pc,
    output logic [ADDR_W-1:0]          bp_query_addr,
    input  logic                       bp_taken,
    input  logic [ADDR_W-1:0]          ras_top,
    output logic                       ic_req_valid,
    output logic [ADDR_W-1:0]          ic_req_addr,
    input  logic                       ic_req_ready,
    input  logic                       ic_resp_valid,
    input  logic [31:0]                ic_resp_inst,
    input  logic                       ic_resp_compressed,
    output logic                       dq_valid,
    input  logic                       dq_ready,
    output logic [31:0]                dq_inst,
    output logic                       dq_compressed,
    output logic [ADDR_W-1:0]          dq_pc,
    output logic                       dq_pred_taken,
    output logic [ADDR_W-1:0]          dq_pred_target,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        DROP
    } state_t;

    state_t            state;
    state_t            state_n;
    logic [ADDR_W-1:0] fetch_pc;
    logic [ADDR_W-1:0] fetch_pc_n;
    logic [ADDR_W-1:0] next_pc;
    logic [ADDR_W-1:0] len;
    logic              taken;
    logic              push;
    logic              pop;
    logic              full;
    logic              is_br;
    logic              is_jal;
    logic              is_jalr;
    logic signed [31:0] b_imm;
    logic signed [31:0] j_imm;

    logic [PW-1:0]     head;
    logic [PW-1:0]     tail;
    logic [31:0]       inst_q [DEPTH];
    logic              comp_q [DEPTH];
    logic [ADDR_W-1:0] pc_q   [DEPTH];
    logic              tk_q   [DEPTH];
    logic [ADDR_W-1:0] tgt_q  [DEPTH];

    assign bp_query_addr = fetch_pc;
    assign ic_req_addr   = fetch_pc;

    assign is_br   = ic_resp_inst[6:0] == 7'b1100011;
    assign is_jal  = ic_resp_inst[6:0] == 7'b1101111;
    assign is_jalr = ic_resp_inst[6:0] == 7'b1100111;

    assign b_imm = {{19{ic_resp_inst[31]}}, ic_resp_inst[31],
                    ic_resp_inst[7], ic_resp_inst[30:25],
                    ic_resp_inst[11:8], 1'b0};
    assign j_imm = {{11{ic_resp_inst[31]}}, ic_resp_inst[31],
                    ic_resp_inst[19:12], ic_resp_inst[20],
                    ic_resp_inst[30:21], 1'b0};

    assign len = ic_resp_compressed ? ADDR_W'(2) : ADDR_W'(4);

    // Signed size casts sign-extend or truncate the immediate to ADDR_W.
    always_comb begin
        taken   = 1'b0;
        next_pc = fetch_pc + len;
        unique case (1'b1)
            is_br: begin
                taken = bp_taken;
                if (bp_taken) next_pc = fetch_pc + ADDR_W'(b_imm);
            end
            is_jal: begin
                taken   = 1'b1;
                next_pc = fetch_pc + ADDR_W'(j_imm);
            end
            is_jalr: begin
                taken   = 1'b1;
                next_pc = ras_top;
            end
            default: ;
        endcase
    end

    assign full     = count == CW'(DEPTH);
    assign dq_valid = count != '0;
    assign pop      = dq_valid & dq_ready & ~flush;

    always_comb begin
        state_n      = state;
        fetch_pc_n   = fetch_pc;
        push         = 1'b0;
        ic_req_valid = 1'b0;
        unique case (state)
            IDLE: begin
                ic_req_valid = rst & ~flush & ~full;
                if (ic_req_valid && ic_req_ready) state_n = WAIT;
            end
            WAIT: begin
                if (ic_resp_valid) begin
                    push       = 1'b1;
                    fetch_pc_n = next_pc;
                    state_n    = IDLE;
                end
            end
            DROP: begin
                if (ic_resp_valid) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
        // A flush outranks everything; an outstanding fetch must be dropped.
        if (flush) begin
            push       = 1'b0;
            fetch_pc_n = flush_pc;
            if (state == IDLE || ic_resp_valid) state_n = IDLE;
            else state_n = DROP;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= IDLE;
            fetch_pc <= RESET_PC;
        end else begin
            state    <= state_n;
            fetch_pc <= fetch_pc_n;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                inst_q[i] <= '0;
                comp_q[i] <= 1'b0;
                pc_q[i]   <= '0;
                tk_q[i]   <= 1'b0;
                tgt_q[i]  <= '0;
            end
        end else if (flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) begin
                inst_q[tail] <= ic_resp_inst;
                comp_q[tail] <= ic_resp_compressed;
                pc_q[tail]   <= fetch_pc;
                tk_q[tail]   <= taken;
                tgt_q[tail]  <= next_pc;
                tail         <= tail + 1'b1;
            end
            if (pop) head <= head + 1'b1;
            if (push && !pop) count <= count + 1'b1;
            else if (pop && !push) count <= count - 1'b1;
        end
    end

    assign dq_inst        = inst_q[head];
    assign dq_compressed  = comp_q[head];
    assign dq_pc          = pc_q[head];
    assign dq_pred_taken  = tk_q[head];
    assign dq_pred_target = tgt_q[head];

    a_no_push_full: assert property (
        @(posedge clk) disable iff (!rst) !(push && full)
    );

endmodule

// File: tb/tb_fetch_buffer.sv
// Self-checking bench for fetch_buffer: scripted icache, scoreboard of
// expected queue entries compared as the decoder pops them.
module tb_fetch_buffer;

    localparam int AW = 17;

    typedef struct {
        logic [31:0]   inst;
        logic          comp;
        logic [AW-1:0] pc;
        logic          tk;
        logic [AW-1:0] tgt;
    } ent_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          flush;
    logic [AW-1:0] flush_pc;
    logic [AW-1:0] bp_query_addr;
    logic          bp_taken;
    logic [AW-1:0] ras_top;
    logic          ic_req_valid;
    logic [AW-1:0] ic_req_addr;
    logic          ic_req_ready;
    logic          ic_resp_valid;
    logic [31:0]   ic_resp_inst;
    logic          ic_resp_compressed;
    logic          dq_valid;
    logic          dq_ready;
    logic [31:0]   dq_inst;
    logic          dq_compressed;
    logic [AW-1:0] dq_pc;
    logic          dq_pred_taken;
    logic [AW-1:0] dq_pred_target;
    logic [2:0]    count;

    ent_t          sb[$];
    logic [AW-1:0] model_pc;
    int            passed = 0;
    int            total = 0;

    always #5 clk = ~clk;

    fetch_buffer #(
        .ADDR_W  (AW),
        .DEPTH   (4),
        .RESET_PC(17'h0)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .flush             (flush),
        .flush_pc          (flush_pc),
        .bp_query_addr     (bp_query_addr),
        .bp_taken          (bp_taken),
        .ras_top           (ras_top),
        .ic_req_valid      (ic_req_valid),
        .ic_req_addr       (ic_req_addr),
        .ic_req_ready      (ic_req_ready),
        .ic_resp_valid     (ic_resp_valid),
        .ic_resp_inst      (ic_resp_inst),
        .ic_resp_compressed(ic_resp_compressed),
        .dq_valid          (dq_valid),
        .dq_ready          (dq_ready),
        .dq_inst           (dq_inst),
        .dq_compressed     (dq_compressed),
        .dq_pc             (dq_pc),
        .dq_pred_taken     (dq_pred_taken),
        .dq_pred_target    (dq_pred_target),
        .count             (count)
    );

    // One cycle; a pop seen before the edge is checked against the scoreboard.
    task automatic step();
        ent_t e;
        #1;
        if (rst && !flush && dq_valid && dq_ready) begin
            total++;
            if (sb.size() == 0) begin
                $display("FAIL pop_unexpected pc=%h with nothing expected", dq_pc);
            end else begin
                e = sb.pop_front();
                if ({dq_inst, dq_compressed, dq_pc, dq_pred_taken, dq_pred_target}
                    !== {e.inst, e.comp, e.pc, e.tk, e.tgt})
                    $display("FAIL pop_entry got inst=%h c=%b pc=%h tk=%b tgt=%h exp inst=%h c=%b pc=%h tk=%b tgt=%h",
                             dq_inst, dq_compressed, dq_pc, dq_pred_taken, dq_pred_target,
                             e.inst, e.comp, e.pc, e.tk, e.tgt);
                else passed++;
            end
        end
        @(negedge clk);
    endtask

    task automatic do_fetch(input logic [31:0] inst, input logic comp,
                            input logic tk_in, input logic [AW-1:0] ras,
                            output logic seen_v, output logic [AW-1:0] seen_a);
        ent_t          e;
        int            imm;
        logic [AW-1:0] len;
        bp_taken     = tk_in;
        ras_top      = ras;
        ic_req_ready = 1'b1;
        #1;
        seen_v = ic_req_valid;
        seen_a = ic_req_addr;
        step();
        ic_req_ready       = 1'b0;
        ic_resp_valid      = 1'b1;
        ic_resp_inst       = inst;
        ic_resp_compressed = comp;
        len    = comp ? 17'd2 : 17'd4;
        e.inst = inst;
        e.comp = comp;
        e.pc   = model_pc;
        e.tk   = 1'b0;
        e.tgt  = model_pc + len;
        case (inst[6:0])
            7'h63: begin
                imm  = $signed({inst[31], inst[7], inst[30:25], inst[11:8], 1'b0});
                e.tk = tk_in;
                if (tk_in) e.tgt = model_pc + AW'(imm);
            end
            7'h6F: begin
                imm   = $signed({inst[31], inst[19:12], inst[20], inst[30:21], 1'b0});
                e.tk  = 1'b1;
                e.tgt = model_pc + AW'(imm);
            end
            7'h67: begin
                e.tk  = 1'b1;
                e.tgt = ras;
            end
            default: ;
        endcase
        sb.push_back(e);
        model_pc = e.tgt;
        step();
        ic_resp_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        step();
        step();
        total++; if (ic_req_valid !== 1'b0) $display("FAIL rst_req got %b exp 0", ic_req_valid); else passed++;
        total++; if ({dq_valid, count} !== 4'b0) $display("FAIL rst_count got v=%b n=%0d exp 0", dq_valid, count); else passed++;
        total++; if ({dq_inst, dq_compressed, dq_pc, dq_pred_taken, dq_pred_target} !== '0)
            $display("FAIL rst_payload got inst=%h pc=%h tgt=%h exp 0", dq_inst, dq_pc, dq_pred_target); else passed++;
        rst = 1'b1;
        #1;
        total++; if ({ic_req_valid, ic_req_addr, bp_query_addr} !== {1'b1, 17'h0, 17'h0})
            $display("FAIL rst_first_req got v=%b a=%h bp=%h exp 1 0 0", ic_req_valid, ic_req_addr, bp_query_addr); else passed++;
        model_pc = 17'h0;
    endtask

    task automatic test_sequential();
        logic          v;
        logic [AW-1:0] a;
        dq_ready = 1'b1;
        do_fetch(32'h00000013, 1'b0, 1'b0, 17'h0, v, a);
        total++; if ({v, a} !== {1'b1, 17'h0}) $display("FAIL seq_req0 got v=%b a=%h exp 1 0", v, a); else passed++;
        total++; if ({dq_valid, dq_pc} !== {1'b1, 17'h0}) $display("FAIL seq_latency got v=%b pc=%h exp 1 0", dq_valid, dq_pc); else passed++;
        do_fetch(32'h00000013, 1'b0, 1'b0, 17'h0, v, a);
        total++; if ({v, a} !== {1'b1, 17'h4}) $display("FAIL seq_req4 got v=%b a=%h exp 1 4", v, a); else passed++;
        do_fetch(32'h00000013, 1'b1, 1'b0, 17'h0, v, a);
        total++; if ({v, a} !== {1'b1, 17'h8}) $display("FAIL seq_req8 got v=%b a=%h exp 1 8", v, a); else passed++;
        #1;
        total++; if ({ic_req_valid, ic_req_addr} !== {1'b1, 17'hA})
            $display("FAIL seq_reqA got v=%b a=%h exp 1 a", ic_req_valid, ic_req_addr); else passed++;
        step();
        step();
        total++; if (count !== 3'd0 || sb.size() != 0)
            $display("FAIL seq_drain got count=%0d left=%0d exp 0 0", count, sb.size()); else passed++;
    endtask

    task automatic test_full();
        logic          v;
        logic [AW-1:0] a;
        logic [AW-1:0] exp_a;
        dq_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            exp_a = model_pc;
            do_fetch(32'h00000013, 1'b0, 1'b0, 17'h0, v, a);
            total++; if ({v, a} !== {1'b1, exp_a}) $display("FAIL full_req%0d got v=%b a=%h exp 1 %h", i, v, a, exp_a); else passed++;
        end
        ic_req_ready = 1'b1;
        #1;
        total++; if ({count, ic_req_valid} !== {3'd4, 1'b0})
            $display("FAIL full_gate got count=%0d v=%b exp 4 0", count, ic_req_valid); else passed++;
        step();
        step();
        total++; if ({count, ic_req_valid} !== {3'd4, 1'b0})
            $display("FAIL full_hold got count=%0d v=%b exp 4 0", count, ic_req_valid); else passed++;
        ic_req_ready = 1'b0;
        dq_ready = 1'b1;
        step();
        dq_ready = 1'b0;
        #1;
        total++; if ({count, ic_req_valid, ic_req_addr} !== {3'd3, 1'b1, model_pc})
            $display("FAIL full_reissue got count=%0d v=%b a=%h exp 3 1 %h", count, ic_req_valid, ic_req_addr, model_pc); else passed++;
        dq_ready = 1'b1;
        repeat (3) step();
        total++; if (count !== 3'd0 || sb.size() != 0)
            $display("FAIL full_drain got count=%0d left=%0d exp 0 0", count, sb.size()); else passed++;
    endtask

    task automatic test_branch();
        logic          v;
        logic [AW-1:0] a;
        dq_ready = 1'b1;
        flush    = 1'b1;
        flush_pc = 17'h10;
        #1;
        total++; if (ic_req_valid !== 1'b0) $display("FAIL br_flush_gate got %b exp 0", ic_req_valid); else passed++;
        step();
        flush    = 1'b0;
        model_pc = 17'h10;
        do_fetch(32'hFE000EE3, 1'b0, 1'b1, 17'h0, v, a);
        total++; if ({v, a} !== {1'b1, 17'h10}) $display("FAIL br_req got v=%b a=%h exp 1 10", v, a); else passed++;
        total++; if ({dq_valid, dq_pred_taken, dq_pred_target} !== {1'b1, 1'b1, 17'hC})
            $display("FAIL br_taken_entry got v=%b tk=%b tgt=%h exp 1 1 c", dq_valid, dq_pred_taken, dq_pred_target); else passed++;
        #1;
        total++; if (ic_req_addr !== 17'hC) $display("FAIL br_taken_next got %h exp c", ic_req_addr); else passed++;
        step();
        flush = 1'b1;
        step();
        flush    = 1'b0;
        model_pc = 17'h10;
        do_fetch(32'hFE000EE3, 1'b0, 1'b0, 17'h0, v, a);
        total++; if ({dq_valid, dq_pred_taken} !== {1'b1, 1'b0})
            $display("FAIL br_nt_entry got v=%b tk=%b exp 1 0", dq_valid, dq_pred_taken); else passed++;
        #1;
        total++; if (ic_req_addr !== 17'h14) $display("FAIL br_nt_next got %h exp 14", ic_req_addr); else passed++;
        step();
    endtask

    task automatic test_jump();
        logic          v;
        logic [AW-1:0] a;
        flush    = 1'b1;
        flush_pc = 17'h20;
        step();
        flush    = 1'b0;
        model_pc = 17'h20;
        do_fetch(32'h0080006F, 1'b0, 1'b0, 17'h0, v, a);
        #1;
        total++; if ({v, a, ic_req_addr} !== {1'b1, 17'h20, 17'h28})
            $display("FAIL jal_next got v=%b a=%h next=%h exp 1 20 28", v, a, ic_req_addr); else passed++;
        do_fetch(32'h00008067, 1'b0, 1'b0, 17'h1234, v, a);
        total++; if ({dq_pred_taken, dq_pred_target} !== {1'b1, 17'h1234})
            $display("FAIL jalr_entry got tk=%b tgt=%h exp 1 1234", dq_pred_taken, dq_pred_target); else passed++;
        #1;
        total++; if ({a, ic_req_addr} !== {17'h28, 17'h1234})
            $display("FAIL jalr_next got a=%h next=%h exp 28 1234", a, ic_req_addr); else passed++;
        step();
    endtask

    task automatic test_flush_drop();
        flush    = 1'b1;
        flush_pc = 17'h30;
        step();
        flush        = 1'b0;
        ic_req_ready = 1'b1;
        #1;
        total++; if ({ic_req_valid, ic_req_addr} !== {1'b1, 17'h30})
            $display("FAIL drop_req got v=%b a=%h exp 1 30", ic_req_valid, ic_req_addr); else passed++;
        step();
        ic_req_ready = 1'b0;
        flush        = 1'b1;
        flush_pc     = 17'h100;
        step();
        flush = 1'b0;
        #1;
        total++; if (ic_req_valid !== 1'b0) $display("FAIL drop_no_req got %b exp 0", ic_req_valid); else passed++;
        step();
        ic_resp_valid      = 1'b1;
        ic_resp_inst       = 32'h00000013;
        ic_resp_compressed = 1'b0;
        step();
        ic_resp_valid = 1'b0;
        #1;
        total++; if ({dq_valid, count, ic_req_valid, ic_req_addr} !== {1'b0, 3'd0, 1'b1, 17'h100})
            $display("FAIL drop_discard got dv=%b n=%0d v=%b a=%h exp 0 0 1 100", dq_valid, count, ic_req_valid, ic_req_addr); else passed++;
        ic_req_ready = 1'b1;
        step();
        ic_req_ready  = 1'b0;
        flush         = 1'b1;
        flush_pc      = 17'h100;
        ic_resp_valid = 1'b1;
        ic_resp_inst  = 32'h0080006F;
        step();
        flush         = 1'b0;
        ic_resp_valid = 1'b0;
        #1;
        total++; if ({dq_valid, ic_req_valid, ic_req_addr} !== {1'b0, 1'b1, 17'h100})
            $display("FAIL coinc_discard got dv=%b v=%b a=%h exp 0 1 100", dq_valid, ic_req_valid, ic_req_addr); else passed++;
        step();
        total++; if ({dq_valid, count} !== 4'b0) $display("FAIL coinc_no_enq got v=%b n=%0d exp 0 0", dq_valid, count); else passed++;
        model_pc = 17'h100;
    endtask

    task automatic test_flush_pop();
        logic          v;
        logic [AW-1:0] a;
        logic [AW-1:0] exp_a;
        dq_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            exp_a = model_pc;
            do_fetch(32'h00000013, 1'b0, 1'b0, 17'h0, v, a);
            total++; if ({v, a} !== {1'b1, exp_a}) $display("FAIL fp_req%0d got v=%b a=%h exp 1 %h", i, v, a, exp_a); else passed++;
        end
        total++; if (count !== 3'd3) $display("FAIL fp_count got %0d exp 3", count); else passed++;
        dq_ready = 1'b1;
        flush    = 1'b1;
        flush_pc = 17'h40;
        step();
        flush = 1'b0;
        sb.delete();
        #1;
        total++; if ({count, dq_valid} !== 4'b0) $display("FAIL fp_clear got n=%0d v=%b exp 0 0", count, dq_valid); else passed++;
        step();
        step();
        total++; if ({count, dq_valid, ic_req_addr} !== {3'd0, 1'b0, 17'h40})
            $display("FAIL fp_after got n=%0d v=%b a=%h exp 0 0 40", count, dq_valid, ic_req_addr); else passed++;
        model_pc = 17'h40;
        dq_ready = 1'b0;
    endtask

    task automatic test_reset_clear();
        logic          v;
        logic [AW-1:0] a;
        dq_ready = 1'b0;
        do_fetch(32'h0080006F, 1'b0, 1'b0, 17'h0, v, a);
        total++; if ({v, a, dq_valid} !== {1'b1, 17'h40, 1'b1})
            $display("FAIL rc_fill got v=%b a=%h dv=%b exp 1 40 1", v, a, dq_valid); else passed++;
        rst = 1'b0;
        step();
        sb.delete();
        total++; if ({dq_valid, count, dq_inst, dq_compressed, dq_pc, dq_pred_taken, dq_pred_target, ic_req_valid} !== '0)
            $display("FAIL rc_clear got v=%b n=%0d inst=%h pc=%h tgt=%h req=%b exp all 0",
                     dq_valid, count, dq_inst, dq_pc, dq_pred_target, ic_req_valid); else passed++;
        rst = 1'b1;
        #1;
        total++; if ({ic_req_valid, ic_req_addr} !== {1'b1, 17'h0})
            $display("FAIL rc_pc got v=%b a=%h exp 1 0", ic_req_valid, ic_req_addr); else passed++;
        model_pc = 17'h0;
    endtask

    initial begin
        rst                = 1'b0;
        flush              = 1'b0;
        flush_pc           = '0;
        bp_taken           = 1'b0;
        ras_top            = '0;
        ic_req_ready       = 1'b0;
        ic_resp_valid      = 1'b0;
        ic_resp_inst       = '0;
        ic_resp_compressed = 1'b0;
        dq_ready           = 1'b0;
        model_pc           = '0;
        @(negedge clk);
        test_reset();
        test_sequential();
        test_full();
        test_branch();
        test_jump();
        test_flush_drop();
        test_flush_pop();
        test_reset_clear();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/fetch_buffer.md
Name: fetch_buffer

Overview:
- Parametrised multi-entry instruction fetch buffer between the icache and the decoder.
- Keeps a predicted fetch PC and issues one icache request at a time over a valid/ready handshake.
- Predicts the next PC from each returned instruction (branch predictor, JAL immediate, return-address-stack top) and queues up to DEPTH decoded-ready entries.
- Supports pipeline flush with discard of an in-flight response; the decoder drains entries over a valid/ready handshake.

Parameters:
ADDR_W, 17, width of all instruction addresses; PC arithmetic is modulo 2^ADDR_W.
DEPTH, 4, queue entries; power of two, >= 2.
RESET_PC, 0, fetch PC loaded on reset.

Ports:
clk  in  1  clock.
rst  in  1  reset, synchronous, active-low.
flush  in  1  redirect: discard queue and in-flight fetch.
flush_pc  in  ADDR_W  new fetch PC on flush.
bp_query_addr  out  ADDR_W  PC presented to the branch predictor; always equals fetch_pc.
bp_taken  in  1  predictor taken bit for bp_query_addr, same cycle.
ras_top  in  ADDR_W  return-address-stack top, used as the JALR target.
ic_req_valid  out  1  icache fetch request.
ic_req_addr  out  ADDR_W  fetch address; equals fetch_pc.
ic_req_ready  in  1  icache accepts the request.
ic_resp_valid  in  1  icache returns an instruction, one cycle pulse.
ic_resp_inst  in  32  returned instruction in 32-bit (expanded) encoding.
ic_resp_compressed  in  1  original instruction is 2 bytes.
dq_valid  out  1  head entry valid.
dq_ready  in  1  decoder consumes head entry.
dq_inst  out  32  head instruction.
dq_compressed  out  1  head is compressed.
dq_pc  out  ADDR_W  head instruction address.
dq_pred_taken  out  1  head predicted to redirect.
dq_pred_target  out  ADDR_W  head predicted next PC.
count  out  $clog2(DEPTH+1)  occupied entries.

Behaviour:
- Reset (rst=0 at posedge):
  - fetch_pc=RESET_PC; state=IDLE; head=tail=count=0; all entry storage cleared.
  - Hence dq_valid=0 and dq_* payload all 0.
  - ic_req_valid=0 while rst=0.
  - The icache shares rst, so no stale response follows a reset.
- FSM states are IDLE, WAIT and DROP.
  - IDLE: ic_req_valid = rst & !flush & (count<DEPTH), combinational. valid&ready -> WAIT. The request is held stable until accepted.
  - WAIT: ic_req_valid=0. ic_resp_valid -> enqueue the entry, fetch_pc<=next_pc, -> IDLE. The next request issues in the following cycle.
  - DROP: ic_req_valid=0. ic_resp_valid -> discard the response (no enqueue, fetch_pc unchanged), -> IDLE.
- Next-PC prediction uses opcode ic_resp_inst[6:0], with len = compressed ? 2 : 4.
  - 1100011 (branch): taken=bp_taken; next = taken ? fetch_pc+sext(Bimm) : fetch_pc+len.
  - 1101111 (JAL): taken=1; next = fetch_pc+sext(Jimm).
  - 1100111 (JALR): taken=1; next = ras_top.
  - Any other opcode: taken=0; next = fetch_pc+len.
  - Immediates are sign-extended or truncated to ADDR_W; sums wrap modulo 2^ADDR_W.
- Each enqueued entry is {inst, compressed, pc=fetch_pc, pred_taken=taken, pred_target=next}.
- Queue:
  - Circular buffer with head/tail pointers that wrap at DEPTH.
  - dq_valid = (count!=0). dq_* show the head entry. A pop occurs on dq_valid & dq_ready.
  - Push and pop in the same cycle leave count unchanged.
  - The issue gate (count<DEPTH before issue; only one request outstanding) guarantees no push while full. A push with count==DEPTH is an assertion failure.
  - Latency: response cycle N -> dq_valid at N+1 when the queue was empty (no combinational bypass).
- Flush (rst=1, flush=1) takes priority over every other event that cycle:
  - head=tail=count=0, so dq_valid=0 next cycle; any same-cycle pop is ignored.
  - fetch_pc<=flush_pc.
  - From IDLE: stay IDLE (no request was issued that cycle because ic_req_valid is gated by flush).
  - From WAIT with no ic_resp_valid: -> DROP.
  - From WAIT with ic_resp_valid the same cycle: the response is discarded, -> IDLE.
  - From DROP: stay in DROP, or go to IDLE if ic_resp_valid is high the same cycle; fetch_pc is updated in both cases.
  - Back-to-back flushes: the last flush_pc wins.

Test Plan:
- Reset, DEPTH=4, ADDR_W=17, dq_ready=1. Responses: 0x00000013 (4B) at 0x0, 0x00000013 (4B) at 0x4, then compressed at 0x8 -> requests to 0x0, 0x4, 0x8, 0xA; dq_pc sequence 0x0, 0x4, 0x8; dq_pred_taken=0 throughout.
- dq_ready=0, four responses -> count=4 and ic_req_valid stays 0. Pulse dq_ready one cycle -> count=3 and a request to the correct next PC in the following cycle.
- 0xFE000EE3 (beq -4) at fetch_pc 0x10:
  - bp_taken=1 -> next request 0x0C; entry has pred_taken=1 and target=0x0C.
  - bp_taken=0 -> next request 0x14; pred_taken=0.
- 0x0080006F (jal +8) at 0x20 -> next request 0x28. Then 0x00008067 (jalr) at 0x28 with ras_top=0x1234 -> next request 0x1234; pred_target=0x1234.
- Request at 0x30 accepted, flush=1 with flush_pc=0x100 before the response -> state DROP, the late response is not enqueued, dq_valid stays 0, next request is 0x100. Repeat with flush coincident with ic_resp_valid -> no enqueue, request 0x100 the next cycle.
- Three entries queued, flush and dq_ready asserted together -> count=0 and dq_valid=0 next cycle; no entry is consumed twice.
